// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and frame constants.
// Imported by the receiver and its helper blocks.
package uart_pkg;

  localparam int CLK_PER_BIT_DEFAULT = 10417;
  localparam int DATA_BITS           = 8;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Both flops reset to 1 so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic meta;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta   <= 1'b1;
      o_sync <= 1'b1;
    end else begin
      meta   <= i_async;
      o_sync <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, qualifies the start bit,
// samples data near mid-bit, and flags a low stop bit as a framing error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clk_per_bit = CLK_PER_BIT_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_serial,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_rx_frame_err,
  output logic       o_rx_busy
);

  localparam int             HALF    = clk_per_bit / 2;
  localparam int             CW      = $clog2(clk_per_bit);
  localparam logic [CW-1:0]  HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0]  LAST    = CW'(clk_per_bit - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  logic            s_rx;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_rx_serial),
    .o_sync  (s_rx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!s_rx) state_d = RX_START;
      end
      // Any high sample while qualifying the start bit is treated as a glitch.
      RX_START: begin
        if (s_rx) begin
          state_d = RX_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == HALF_M1) begin
          state_d = RX_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = s_rx;
          bit_d          = bit_q + 3'd1;
          if (bit_q == LAST_BIT) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (s_rx) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // Wait out a held-low line so it is not decoded as a stream of 0x00.
      RX_BREAK: begin
        cnt_d = '0;
        if (s_rx) state_d = RX_IDLE;
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_rx_byte      = byte_q;
  assign o_rx_valid     = valid_q;
  assign o_rx_frame_err = err_q;
  assign o_rx_busy      = (state_q != RX_IDLE);

endmodule
